// File: rtl/fifo_wr_arb_pkg.sv
// Shared types for the FIFO write arbiter: FSM state encoding and stats counter width.
// Combinational content only; no latency or backpressure of its own.
package fifo_wr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int STAT_WIDTH = 16;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin search: first set bit of req at or above ptr, wrapping; purely combinational.
// Zero latency; no backpressure (found=0 when req is empty).
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 found,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IDW = $clog2(N);
  localparam logic [IDW:0] N_W = (IDW+1)'(N);

  logic [IDW:0]   sum;
  logic [IDW-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest valid index wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= N_W) sum = sum - N_W;
      cand = sum[IDW-1:0];
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter onto one FIFO write port; one IDLE cycle per grant, beats pass combinationally.
// fifo_wr_full stalls the burst and drops req_ready; FIFO_WR_ARB_STATS_EN adds per-requester beat counters.
module fifo_wr_arbiter
  import fifo_wr_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int N_REQ      = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                          wr_clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ-1:0]              req_last,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]              req_ready,
  input  logic                          fifo_wr_full,
  output logic                          fifo_wr_inc,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic [$clog2(N_REQ)-1:0]      grant_id,
  output logic                          busy
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [N_REQ*STAT_WIDTH-1:0]   stat_beats
`endif
);

  localparam int IDW = $clog2(N_REQ);

  arb_state_e     state_q;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] grant_q;
  logic [8:0]     cnt_q, cnt_d;
  logic           busy_q;

  logic           pick_found;
  logic [IDW-1:0] pick_idx;
  logic           in_burst;
  logic           xfer;
  logic           burst_end;

  rr_pick #(
    .N (N_REQ)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign in_burst  = (state_q == BURST);
  assign xfer      = in_burst & req_valid[grant_q] & ~fifo_wr_full;
  assign burst_end = xfer & (req_last[grant_q] | (cnt_q == 9'(MAX_BURST - 1)));
  assign cnt_d     = cnt_q + 9'd1;
  assign rr_ptr_d  = (grant_q == IDW'(N_REQ - 1)) ? '0 : grant_q + IDW'(1);

  always_comb begin
    req_ready = '0;
    if (in_burst) req_ready[grant_q] = ~fifo_wr_full;
  end

  assign fifo_wr_inc  = xfer;
  assign fifo_wr_data = req_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
  assign grant_id     = grant_q;
  assign busy         = busy_q;

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            state_q <= BURST;
            grant_q <= pick_idx;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        BURST: begin
          // Stalls (full or granted valid low) hold everything; no preemption.
          if (xfer) begin
            cnt_q <= cnt_d;
            if (burst_end) begin
              state_q  <= IDLE;
              busy_q   <= 1'b0;
              rr_ptr_q <= rr_ptr_d;
            end
          end
        end
      endcase
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [STAT_WIDTH-1:0] stat_q [N_REQ];

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) stat_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (xfer && (grant_q == IDW'(i)) && (stat_q[i] != '1))
          stat_q[i] <= stat_q[i] + STAT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    stat_beats = '0;
    for (int i = 0; i < N_REQ; i++) stat_beats[i*STAT_WIDTH +: STAT_WIDTH] = stat_q[i];
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (N_REQ=4, MAX_BURST=4, DATA_WIDTH=8), cycle-exact expectations.
// Optional FIFO_WR_ARB_STATS_EN checks the beat counters as well.
module tb_fifo_wr_arbiter;

  logic        wr_clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_wr_full;
  logic        fifo_wr_inc;
  logic [7:0]  fifo_wr_data;
  logic [1:0]  grant_id;
  logic        busy;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [63:0] stat_beats;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 wr_clk = ~wr_clk;

  fifo_wr_arbiter #(
    .DATA_WIDTH (8),
    .N_REQ      (4),
    .MAX_BURST  (4)
  ) dut (
    .wr_clk       (wr_clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_wr_full (fifo_wr_full),
    .fifo_wr_inc  (fifo_wr_inc),
    .fifo_wr_data (fifo_wr_data),
    .grant_id     (grant_id),
    .busy         (busy)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .stat_beats   (stat_beats)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: check outputs at the falling edge, then step past the rising edge.
  task automatic cyc(input string tag, input logic e_inc, input logic [7:0] e_dat,
                     input logic e_busy, input logic [1:0] e_gid, input logic [3:0] e_rdy);
    @(negedge wr_clk);
    chk({tag, ".inc"}, 32'(fifo_wr_inc), 32'(e_inc));
    if (e_inc) chk({tag, ".dat"}, 32'(fifo_wr_data), 32'(e_dat));
    chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
    chk({tag, ".rdy"}, 32'(req_ready), 32'(e_rdy));
    if (e_busy) chk({tag, ".gid"}, 32'(grant_id), 32'(e_gid));
    @(posedge wr_clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    req_valid    = '0;
    req_last     = '0;
    req_data     = '0;
    fifo_wr_full = 1'b0;
    @(posedge wr_clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n        = 1'b0;
    req_valid    = '0;
    req_last     = '0;
    req_data     = '0;
    fifo_wr_full = 1'b0;
    repeat (2) @(posedge wr_clk);
    @(negedge wr_clk);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.gid", 32'(grant_id), 32'd0);
    chk("rst.inc", 32'(fifo_wr_inc), 32'd0);
    chk("rst.rdy", 32'(req_ready), 32'd0);
`ifdef FIFO_WR_ARB_STATS_EN
    chk("rst.stat", stat_beats[31:0], 32'd0);
`endif
    @(posedge wr_clk);
    #1;
    rst_n = 1'b1;

    // Three-beat burst from req0, then rr_ptr=1 proven by req1 winning over req0.
    req_valid = 4'b0001; req_data[7:0] = 8'h11;
    cyc("A0", 0, 8'h00, 0, 2'd0, 4'b0000);
    cyc("A1", 1, 8'h11, 1, 2'd0, 4'b0001);
    req_data[7:0] = 8'h22;
    cyc("A2", 1, 8'h22, 1, 2'd0, 4'b0001);
    req_data[7:0] = 8'h33; req_last = 4'b0001;
    cyc("A3", 1, 8'h33, 1, 2'd0, 4'b0001);
    req_valid = 4'b0000; req_last = 4'b0000;
    cyc("A4", 0, 8'h00, 0, 2'd0, 4'b0000);
    req_valid = 4'b0011; req_last = 4'b0011; req_data[15:0] = 16'h0201;
    cyc("A5", 0, 8'h00, 0, 2'd0, 4'b0000);
    cyc("A6", 1, 8'h02, 1, 2'd1, 4'b0010);
    req_valid = 4'b0000; req_last = 4'b0000;
    cyc("A7", 0, 8'h00, 0, 2'd0, 4'b0000);

    // All four valid with single-beat bursts: 0,1,2,3,0 with a bubble between.
    do_reset();
    req_valid = 4'b1111; req_last = 4'b1111; req_data = 32'hA3A2A1A0;
    for (int k = 0; k < 5; k++) begin
      cyc($sformatf("B%0d.idle", k), 0, 8'h00, 0, 2'd0, 4'b0000);
      cyc($sformatf("B%0d.beat", k), 1, 8'hA0 + 8'(k % 4), 1, 2'(k % 4), 4'(1 << (k % 4)));
    end
    req_valid = 4'b0000; req_last = 4'b0000;
    cyc("B.end", 0, 8'h00, 0, 2'd0, 4'b0000);

    // Req2 offers six beats with no last: split 4 + 2, then grant held with valid low.
    do_reset();
    req_valid = 4'b0100;
    cyc("C.idle0", 0, 8'h00, 0, 2'd0, 4'b0000);
    for (int b = 0; b < 6; b++) begin
      req_data[23:16] = 8'h50 + 8'(b);
      if (b == 4) cyc("C.bubble", 0, 8'h00, 0, 2'd0, 4'b0000);
      cyc($sformatf("C.beat%0d", b), 1, 8'h50 + 8'(b), 1, 2'd2, 4'b0100);
    end
    req_valid = 4'b0000;
    cyc("C.hold0", 0, 8'h00, 1, 2'd2, 4'b0100);
    cyc("C.hold1", 0, 8'h00, 1, 2'd2, 4'b0100);

    // FIFO full for three cycles while beat 2 is pending.
    do_reset();
    req_valid = 4'b0010;
    cyc("D.idle", 0, 8'h00, 0, 2'd0, 4'b0000);
    req_data[15:8] = 8'h61;
    cyc("D.b1", 1, 8'h61, 1, 2'd1, 4'b0010);
    req_data[15:8] = 8'h62; fifo_wr_full = 1'b1;
    for (int s = 0; s < 3; s++) cyc($sformatf("D.stall%0d", s), 0, 8'h00, 1, 2'd1, 4'b0000);
    fifo_wr_full = 1'b0;
    cyc("D.b2", 1, 8'h62, 1, 2'd1, 4'b0010);
    req_data[15:8] = 8'h63;
    cyc("D.b3", 1, 8'h63, 1, 2'd1, 4'b0010);
    req_data[15:8] = 8'h64; req_last = 4'b0010;
    cyc("D.b4", 1, 8'h64, 1, 2'd1, 4'b0010);
    req_valid = 4'b0000; req_last = 4'b0000;
    cyc("D.end", 0, 8'h00, 0, 2'd0, 4'b0000);

    // Reset mid-burst after two beats from req3.
    do_reset();
    req_valid = 4'b1000;
    cyc("E.idle", 0, 8'h00, 0, 2'd0, 4'b0000);
    req_data[31:24] = 8'h71;
    cyc("E.b1", 1, 8'h71, 1, 2'd3, 4'b1000);
    req_data[31:24] = 8'h72;
    cyc("E.b2", 1, 8'h72, 1, 2'd3, 4'b1000);
`ifdef FIFO_WR_ARB_STATS_EN
    chk("E.stat3", 32'(stat_beats[63:48]), 32'd2);
`endif
    req_data[31:24] = 8'h73;
    rst_n = 1'b0;
    @(negedge wr_clk);
    chk("E.rst.inc", 32'(fifo_wr_inc), 32'd0);
    chk("E.rst.busy", 32'(busy), 32'd0);
    chk("E.rst.gid", 32'(grant_id), 32'd0);
    chk("E.rst.rdy", 32'(req_ready), 32'd0);
`ifdef FIFO_WR_ARB_STATS_EN
    chk("E.rst.stat", 32'(stat_beats[63:48]), 32'd0);
`endif
    req_valid = 4'b0000;
    @(posedge wr_clk);
    #1;
    rst_n = 1'b1;
    cyc("E.post0", 0, 8'h00, 0, 2'd0, 4'b0000);
    cyc("E.post1", 0, 8'h00, 0, 2'd0, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, 8: beat width; SHALL equal the width of the FIFO write port.
REQ-002 Parameter N_REQ, 4: number of requesters; legal range 2..8.
REQ-003 Parameter MAX_BURST, 4: maximum beats per grant; legal range 1..256.
REQ-004 Port wr_clk  in  1: write-domain clock; all state SHALL be on its rising edge.
REQ-005 Port rst_n  in  1: reset, asynchronous, active-low.
REQ-006 Port req_valid  in  N_REQ: per-requester beat valid.
REQ-007 Port req_last  in  N_REQ: per-requester end-of-burst marker, qualified by req_valid.
REQ-008 Port req_data  in  N_REQ*DATA_WIDTH: requester i at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 Port req_ready  out  N_REQ: per-requester beat accept.
REQ-010 Port fifo_wr_full  in  1: FIFO full flag, write domain.
REQ-011 Port fifo_wr_inc  out  1: FIFO write strobe.
REQ-012 Port fifo_wr_data  out  DATA_WIDTH: FIFO write data.
REQ-013 Port grant_id  out  clog2(N_REQ): index of the current grant holder.
REQ-014 Port busy  out  1: high while a grant is held.

Function
REQ-015 The FSM SHALL have two states, IDLE and BURST.
REQ-016 In IDLE with any req_valid high, the arbiter SHALL pick the first valid index searching upward from rr_ptr with wrap, register it into grant_id, and enter BURST next cycle.
REQ-017 In IDLE, req_ready and fifo_wr_inc SHALL be 0; the first beat therefore transfers no earlier than 1 cycle after valid.
REQ-018 In BURST, req_ready[grant_id] SHALL equal ~fifo_wr_full; all other req_ready bits SHALL be 0.
REQ-019 In BURST, fifo_wr_inc SHALL equal req_valid[grant_id] & ~fifo_wr_full, combinationally, and fifo_wr_data SHALL equal the granted slice of req_data.
REQ-020 A beat SHALL transfer exactly when fifo_wr_inc=1; the 9-bit beat counter SHALL increment on each transfer and clear on entry to BURST.
REQ-021 BURST SHALL end, returning to IDLE next cycle, on a transfer with req_last[grant_id]=1 or on the MAX_BURST-th transfer, whichever comes first.
REQ-022 At burst end, rr_ptr SHALL become (grant_id+1) mod N_REQ.
REQ-023 fifo_wr_full=1 SHALL stall the burst: no transfer, counter held, grant held, no timeout.
REQ-024 The granted requester deasserting valid mid-burst SHALL keep the grant; there SHALL be no preemption.
REQ-025 Other requesters' valid, last and data SHALL be ignored while in BURST.
REQ-026 A one-cycle IDLE bubble SHALL separate consecutive grants, including re-grant to the same requester.
REQ-027 busy SHALL be 1 exactly in BURST.

Reset
REQ-028 While rst_n=0, the FSM SHALL be IDLE and rr_ptr, grant_id, the beat counter and busy SHALL be 0; consequently req_ready=0 and fifo_wr_inc=0.
REQ-029 Reset asserted mid-burst SHALL abandon the burst with no further FIFO writes; release SHALL be synchronous to wr_clk.

Configuration
REQ-030 With macro FIFO_WR_ARB_STATS_EN defined, output port stat_beats (N_REQ*16) SHALL exist, holding per-requester saturating counts of transferred beats, reset to 0.
REQ-031 Without FIFO_WR_ARB_STATS_EN, the port and its counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-032 Package fifo_wr_arb_pkg SHALL hold the state enum typedef (IDLE, BURST) and the constant STAT_WIDTH=16.
REQ-033 The round-robin search SHALL be a combinational sub-module rr_pick with inputs req and ptr and outputs found and idx.

Verification (N_REQ=4, MAX_BURST=4, DATA_WIDTH=8)
REQ-034 Req0 sends 3 beats 0x11,0x22,0x33 (last on the 3rd), FIFO never full -> fifo_wr_inc high cycles 2-4, data in order; busy falls after beat 3; rr_ptr=1.
REQ-035 Req0..3 all valid continuously, single-beat bursts -> grants 0,1,2,3,0, each separated by one IDLE cycle.
REQ-036 Req2 sends 6 beats with no last -> 4 beats written, then IDLE; the remaining 2 beats go in the next grant to req2 (only requester valid).
REQ-037 fifo_wr_full=1 for 3 cycles during beat 2 of a 4-beat burst -> fifo_wr_inc=0 and req_ready=0 for those cycles; all 4 beats are written exactly once, in order.
REQ-038 rst_n pulsed low after beat 2 of a 4-beat burst -> no further fifo_wr_inc; busy=0, grant_id=0; with stats enabled, stat_beats cleared.
